// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared widths, opcode encodings and FSM states for alu_arbiter
package alu_arb_pkg;

    localparam int ALU_W = 4;
    localparam int OP_W  = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR = 3'b100;
    localparam logic [OP_W-1:0] OP_NOT = 3'b101;
    localparam logic [OP_W-1:0] OP_SHL = 3'b110;
    localparam logic [OP_W-1:0] OP_SHR = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// behavioral_alu: combinational 4-bit ALU with carry/borrow output
module behavioral_alu
    import alu_arb_pkg::*;
(
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [ALU_W-1:0] result,
    output logic             carry
);

    logic [ALU_W:0] sum;
    logic [ALU_W:0] diff;

    // diff[ALU_W] is the borrow: set exactly when a < b
    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        diff   = {1'b0, a} - {1'b0, b};
        result = sum[ALU_W-1:0];
        carry  = 1'b0;
        case (op)
            OP_ADD:  {carry, result} = sum;
            OP_SUB:  {carry, result} = diff;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOT:  result = ~a;
            OP_SHL:  result = {a[ALU_W-2:0], 1'b0};
            OP_SHR:  result = {1'b0, a[ALU_W-1:1]};
            default: result = sum[ALU_W-1:0];
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one behavioral_alu between two valid/ready requesters
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [ALU_W-1:0] req0_a,
    input  logic [ALU_W-1:0] req0_b,
    input  logic [OP_W-1:0]  req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [ALU_W-1:0] req1_a,
    input  logic [ALU_W-1:0] req1_b,
    input  logic [OP_W-1:0]  req1_op,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [ALU_W-1:0] resp_result,
    output logic             resp_carry,
    output logic             busy,
    output logic [CNT_W-1:0] done_cnt0,
    output logic [CNT_W-1:0] done_cnt1
);

    state_t           state_q, state_d;
    logic [ALU_W-1:0] a_q, a_d, b_q, b_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic             id_q, id_d;
    logic             last_grant_q, last_grant_d;
    logic             resp_valid_q, resp_valid_d;
    logic             resp_id_q, resp_id_d;
    logic [ALU_W-1:0] resp_result_q, resp_result_d;
    logic             resp_carry_q, resp_carry_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] done_cnt0_q, done_cnt0_d, done_cnt1_q, done_cnt1_d;
    logic [ALU_W-1:0] alu_result;
    logic             alu_carry;
    logic             idle, gnt0, gnt1, deliver;

    behavioral_alu u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (alu_result),
        .carry  (alu_carry)
    );

    // A contended grant goes to whichever requester did not win last time
    always_comb begin
        idle          = state_q == IDLE;
        gnt0          = req0_valid & (!req1_valid | last_grant_q);
        gnt1          = req1_valid & (!req0_valid | !last_grant_q);
        req0_ready    = idle & gnt0;
        req1_ready    = idle & gnt1;
        deliver       = resp_valid_q & resp_ready;
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        op_d          = op_q;
        id_d          = id_q;
        last_grant_d  = last_grant_q;
        resp_valid_d  = resp_valid_q;
        resp_id_d     = resp_id_q;
        resp_result_d = resp_result_q;
        resp_carry_d  = resp_carry_q;
        case (state_q)
            IDLE: begin
                if (gnt0 | gnt1) begin
                    state_d      = EXEC;
                    a_d          = gnt1 ? req1_a : req0_a;
                    b_d          = gnt1 ? req1_b : req0_b;
                    op_d         = gnt1 ? req1_op : req0_op;
                    id_d         = gnt1;
                    last_grant_d = gnt1;
                end
            end
            EXEC: begin
                state_d       = RESP;
                resp_valid_d  = 1'b1;
                resp_id_d     = id_q;
                resp_result_d = alu_result;
                resp_carry_d  = alu_carry;
            end
            RESP: begin
                state_d      = deliver ? IDLE : RESP;
                resp_valid_d = !deliver;
            end
            default: state_d = IDLE;
        endcase
        busy_d      = state_d != IDLE;
        done_cnt0_d = done_cnt0_q + CNT_W'(deliver & !resp_id_q);
        done_cnt1_d = done_cnt1_q + CNT_W'(deliver & resp_id_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            a_q           <= '0;
            b_q           <= '0;
            op_q          <= '0;
            id_q          <= 1'b0;
            last_grant_q  <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= 1'b0;
            resp_result_q <= '0;
            resp_carry_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_cnt0_q   <= '0;
            done_cnt1_q   <= '0;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            op_q          <= op_d;
            id_q          <= id_d;
            last_grant_q  <= last_grant_d;
            resp_valid_q  <= resp_valid_d;
            resp_id_q     <= resp_id_d;
            resp_result_q <= resp_result_d;
            resp_carry_q  <= resp_carry_d;
            busy_q        <= busy_d;
            done_cnt0_q   <= done_cnt0_d;
            done_cnt1_q   <= done_cnt1_d;
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_id     = resp_id_q;
    assign resp_result = resp_result_q;
    assign resp_carry  = resp_carry_q;
    assign busy        = busy_q;
    assign done_cnt0   = done_cnt0_q;
    assign done_cnt1   = done_cnt1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter, with a CNT_W=2 twin for counter wrap
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [2:0] req0_op = '0, req1_op = '0;
    logic       resp_ready = 1'b1;
    logic       req0_ready, req1_ready, resp_valid, resp_id, resp_carry, busy;
    logic [3:0] resp_result;
    logic [7:0] done_cnt0, done_cnt1;
    logic       w2_req0_ready, w2_req1_ready, w2_resp_valid, w2_resp_id, w2_resp_carry, w2_busy;
    logic [3:0] w2_resp_result;
    logic [1:0] w2_done_cnt0, w2_done_cnt1;

    int         checks = 0;
    int         errors = 0;
    logic [5:0] exp_q[$];
    bit         order_q[$];
    logic [5:0] mon_e;

    always #5 clk = ~clk;

    alu_arbiter #(.CNT_W(8)) u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_carry(resp_carry), .busy(busy),
        .done_cnt0(done_cnt0), .done_cnt1(done_cnt1)
    );

    alu_arbiter #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(w2_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(w2_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .resp_valid(w2_resp_valid), .resp_ready(resp_ready), .resp_id(w2_resp_id),
        .resp_result(w2_resp_result), .resp_carry(w2_resp_carry), .busy(w2_busy),
        .done_cnt0(w2_done_cnt0), .done_cnt1(w2_done_cnt1)
    );

    function automatic logic [4:0] model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        int   ia, ib, r;
        logic c;
        ia = int'(a);
        ib = int'(b);
        c  = 1'b0;
        case (op)
            3'd0: begin r = (ia + ib) % 16; c = (ia + ib) > 15; end
            3'd1: begin r = (ia - ib + 16) % 16; c = ia < ib; end
            3'd2: r = int'(a & b);
            3'd3: r = int'(a | b);
            3'd4: r = int'(a ^ b);
            3'd5: r = 15 - ia;
            3'd6: r = (ia * 2) % 16;
            default: r = ia / 2;
        endcase
        return {c, 4'(r)};
    endfunction

    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected: got id=%0d result=%h carry=%0d, required no response", resp_id, resp_result, resp_carry);
            end else begin
                mon_e = exp_q.pop_front();
                if ({resp_id, resp_carry, resp_result} !== mon_e) begin
                    errors++;
                    $display("FAIL resp_data: got id=%0d carry=%0d result=%h, required id=%0d carry=%0d result=%h",
                             resp_id, resp_carry, resp_result, mon_e[5], mon_e[4], mon_e[3:0]);
                end
            end
        end
    end

    task automatic set_req(input bit id, input logic v, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        if (id) begin
            req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
        end
    endtask

    // Leaves valid high; returns just after the accepting edge
    task automatic issue(input bit id, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        bit got = 0;
        @(posedge clk); #1;
        set_req(id, 1'b1, a, b, op);
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            checks++;
            if (req0_ready && req1_ready) begin
                errors++;
                $display("FAIL two_ready: got req0_ready=1 req1_ready=1, required at most one");
            end
            if (id ? req1_ready : req0_ready) begin
                got = 1;
                exp_q.push_back({id, model(op, a, b)});
                order_q.push_back(id);
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: requester %0d got no ready in 40 cycles, required a grant", id);
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d responses outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        order_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({resp_valid, resp_id, resp_result, resp_carry, busy, done_cnt0, done_cnt1} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%0d id=%0d result=%h carry=%0d busy=%0d cnt0=%0d cnt1=%0d, required all 0",
                     resp_valid, resp_id, resp_result, resp_carry, busy, done_cnt0, done_cnt1);
        end
        checks++;
        if ({w2_req0_ready, w2_req1_ready, w2_resp_valid, w2_resp_id, w2_resp_result, w2_resp_carry, w2_busy, w2_done_cnt0, w2_done_cnt1} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_cnt2: got nonzero outputs on CNT_W=2 instance, required all 0");
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle_ready: got ready0=%0d ready1=%0d busy=%0d, required 0 0 0", req0_ready, req1_ready, busy);
        end
    endtask

    task automatic test_add();
        issue(1'b0, 4'h9, 4'h8, OP_ADD);
        set_req(1'b0, 1'b0, 4'h0, 4'h0, OP_ADD);
        @(negedge clk);
        checks++;
        if ({resp_valid, busy} !== 2'b01) begin
            errors++;
            $display("FAIL add_latency_exec: got resp_valid=%0d busy=%0d, required 0 1", resp_valid, busy);
        end
        @(negedge clk);
        checks++;
        if ({resp_valid, resp_id, resp_carry, resp_result} !== {1'b1, 1'b0, 1'b1, 4'h1}) begin
            errors++;
            $display("FAIL add_resp: got valid=%0d id=%0d carry=%0d result=%h, required 1 0 1 1", resp_valid, resp_id, resp_carry, resp_result);
        end
        @(posedge clk); #1;
        checks++;
        if (done_cnt0 !== 8'd1) begin
            errors++;
            $display("FAIL add_done_cnt0: got %0d, required 1", done_cnt0);
        end
    endtask

    task automatic test_sub();
        issue(1'b1, 4'h3, 4'h5, OP_SUB);
        set_req(1'b1, 1'b0, 4'h0, 4'h0, OP_ADD);
        drain();
        issue(1'b1, 4'h5, 4'h3, OP_SUB);
        set_req(1'b1, 1'b0, 4'h0, 4'h0, OP_ADD);
        drain();
        checks++;
        if (done_cnt1 !== 8'd2) begin
            errors++;
            $display("FAIL sub_done_cnt1: got %0d, required 2", done_cnt1);
        end
    endtask

    task automatic test_mixed();
        int   n0 = 0, n1 = 0;
        logic [7:0] base0, base1;
        bit   id;
        base0 = done_cnt0;
        base1 = done_cnt1;
        for (int i = 0; i < 24; i++) begin
            id = 1'($urandom_range(0, 1));
            issue(id, 4'($urandom), 4'($urandom), 3'(i % 8));
            set_req(id, 1'b0, 4'h0, 4'h0, OP_ADD);
            if (id) n1++; else n0++;
        end
        drain();
        checks++;
        if ({done_cnt0, done_cnt1} !== {8'(int'(base0) + n0), 8'(int'(base1) + n1)}) begin
            errors++;
            $display("FAIL mixed_counts: got cnt0=%0d cnt1=%0d, required %0d %0d", done_cnt0, done_cnt1, 8'(int'(base0) + n0), 8'(int'(base1) + n1));
        end
    endtask

    task automatic test_round_robin();
        pulse_reset();
        fork
            begin
                for (int i = 0; i < 4; i++) issue(1'b0, 4'(i + 1), 4'h7, OP_ADD);
                set_req(1'b0, 1'b0, 4'h0, 4'h0, OP_ADD);
            end
            begin
                for (int j = 0; j < 4; j++) issue(1'b1, 4'(j + 2), 4'h3, OP_XOR);
                set_req(1'b1, 1'b0, 4'h0, 4'h0, OP_ADD);
            end
        join
        drain();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (k >= order_q.size() || order_q[k] !== 1'(k % 2)) begin
                errors++;
                $display("FAIL rr_order[%0d]: got %0d, required %0d", k, k < order_q.size() ? int'(order_q[k]) : -1, k % 2);
            end
        end
        checks++;
        if ({done_cnt0, done_cnt1} !== {8'd4, 8'd4}) begin
            errors++;
            $display("FAIL rr_counts: got cnt0=%0d cnt1=%0d, required 4 4", done_cnt0, done_cnt1);
        end
    endtask

    task automatic test_backpressure();
        int   n = 0;
        logic [7:0] base0;
        base0 = done_cnt0;
        resp_ready = 1'b0;
        issue(1'b0, 4'hA, 4'h6, OP_XOR);
        set_req(1'b0, 1'b0, 4'h0, 4'h0, OP_ADD);
        set_req(1'b1, 1'b1, 4'h7, 4'h7, OP_ADD);
        while (!resp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if ({resp_valid, resp_id, resp_carry, resp_result, req0_ready, req1_ready} !== {1'b1, 1'b0, 1'b0, 4'hC, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid=%0d id=%0d carry=%0d result=%h rdy0=%0d rdy1=%0d, required 1 0 0 c 0 0",
                         i, resp_valid, resp_id, resp_carry, resp_result, req0_ready, req1_ready);
            end
        end
        @(posedge clk); #1;
        set_req(1'b1, 1'b0, 4'h0, 4'h0, OP_ADD);
        resp_ready = 1'b1;
        drain();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, resp_valid, done_cnt0} !== {1'b0, 1'b0, 8'(base0 + 8'd1)}) begin
            errors++;
            $display("FAIL bp_release: got busy=%0d valid=%0d cnt0=%0d, required 0 0 %0d", busy, resp_valid, done_cnt0, base0 + 8'd1);
        end
    endtask

    task automatic test_reset_mid_exec();
        issue(1'b0, 4'h3, 4'h0, OP_NOT);
        set_req(1'b0, 1'b0, 4'h0, 4'h0, OP_ADD);
        rst = 1'b1;
        exp_q.delete();
        #1;
        checks++;
        if ({resp_valid, resp_id, resp_result, resp_carry, busy, done_cnt0, done_cnt1} !== '0) begin
            errors++;
            $display("FAIL rst_exec_outputs: got valid=%0d id=%0d result=%h carry=%0d busy=%0d cnt0=%0d cnt1=%0d, required all 0",
                     resp_valid, resp_id, resp_result, resp_carry, busy, done_cnt0, done_cnt1);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({resp_valid, busy} !== 2'b00) begin
                errors++;
                $display("FAIL rst_exec_no_resp[%0d]: got valid=%0d busy=%0d, required 0 0", i, resp_valid, busy);
            end
        end
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, 4'h6, 4'h5, OP_OR);
        set_req(1'b1, 1'b1, 4'h1, 4'h1, OP_AND);
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL rst_first_grant: got rdy0=%0d rdy1=%0d, required 1 0", req0_ready, req1_ready);
        end
        if (req0_ready) exp_q.push_back({1'b0, model(OP_OR, 4'h6, 4'h5)});
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 4'h0, 4'h0, OP_ADD);
        set_req(1'b1, 1'b0, 4'h0, 4'h0, OP_ADD);
        drain();
    endtask

    task automatic test_counter_wrap();
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            issue(1'b0, 4'h9, 4'(i), OP_SHL);
            set_req(1'b0, 1'b0, 4'h0, 4'h0, OP_ADD);
        end
        drain();
        checks++;
        if ({w2_done_cnt0, done_cnt0} !== {2'd1, 8'd5}) begin
            errors++;
            $display("FAIL cnt_wrap: got cnt0(w2)=%0d cnt0(w8)=%0d, required 1 5", w2_done_cnt0, done_cnt0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mixed();
        test_round_robin();
        test_backpressure();
        test_reset_mid_exec();
        test_counter_wrap();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left: got %0d pending, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
